// File: rtl/kb_scan_decoder.sv
// PS/2 scan-code decoder: tracks shift/caps state from make/break bytes and
// queues ordinary make codes with their letter case in a small FWFT FIFO.
module kb_scan_decoder #(
  parameter int unsigned W_SIZE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       rd_key,
  output logic       key_empty,
  output logic [7:0] scan_code,
  output logic       letter_case,
  output logic       caps_lock,
  output logic       overflow_tick
);

  localparam int unsigned DEPTH = 1 << W_SIZE;
  localparam int unsigned PW    = W_SIZE + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  typedef struct packed {
    logic       letter_case;
    logic [7:0] code;
  } key_entry_t;

  state_t          state_q, state_d;
  logic            lshift_q, lshift_d;
  logic            rshift_q, rshift_d;
  logic            caps_held_q, caps_held_d;
  logic            caps_lock_q, caps_lock_d;
  logic            overflow_q, overflow_d;
  logic            key_empty_q, key_empty_d;
  key_entry_t      head_q, head_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  key_entry_t      mem_q [DEPTH];
  key_entry_t      mem_d [DEPTH];

  logic            push_req;
  key_entry_t      push_entry;
  logic            full;
  logic            pop;
  logic            push;

  // Byte-level decoder: prefix tracking, modifier state and push requests
  always_comb begin
    state_d     = state_q;
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_held_d = caps_held_q;
    caps_lock_d = caps_lock_q;
    push_req    = 1'b0;
    // Case is taken from the state before this byte's own update
    push_entry.letter_case = (lshift_q | rshift_q) ^ caps_lock_q;
    push_entry.code        = rx_data;

    if (rx_done_tick) begin
      unique case (state_q)
        IDLE: begin
          case (rx_data)
            8'hF0: state_d  = BRK;
            8'hE0: state_d  = EXT;
            8'h12: lshift_d = 1'b1;
            8'h59: rshift_d = 1'b1;
            8'h58: begin
              // Held caps key repeats must not keep toggling
              if (!caps_held_q) begin
                caps_lock_d = ~caps_lock_q;
                caps_held_d = 1'b1;
              end
            end
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: push_req = 1'b1;
          endcase
        end
        BRK: begin
          case (rx_data)
            8'h12:   lshift_d    = 1'b0;
            8'h59:   rshift_d    = 1'b0;
            8'h58:   caps_held_d = 1'b0;
            default: ;
          endcase
          state_d = IDLE;
        end
        EXT: begin
          // Extended keys (incl. fake shifts) are swallowed entirely
          state_d = (rx_data == 8'hF0) ? EXT_BRK : IDLE;
        end
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO control: one-slot-extra pointers, next-head precompute for FWFT
  always_comb begin
    mem_d      = mem_q;
    full       = (wr_ptr_q[W_SIZE] != rd_ptr_q[W_SIZE]) &&
                 (wr_ptr_q[W_SIZE-1:0] == rd_ptr_q[W_SIZE-1:0]);
    pop        = rd_key & ~key_empty_q;
    push       = push_req & (~full | pop);
    overflow_d = push_req & full & ~pop;
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    if (push) begin
      mem_d[wr_ptr_q[W_SIZE-1:0]] = push_entry;
    end
    key_empty_d = (wr_ptr_d == rd_ptr_d);
    head_d      = key_empty_d ? '0 : mem_d[rd_ptr_d[W_SIZE-1:0]];
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_held_q <= 1'b0;
      caps_lock_q <= 1'b0;
      overflow_q  <= 1'b0;
      key_empty_q <= 1'b1;
      head_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_held_q <= caps_held_d;
      caps_lock_q <= caps_lock_d;
      overflow_q  <= overflow_d;
      key_empty_q <= key_empty_d;
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_q       <= mem_d;
    end
  end

  assign key_empty     = key_empty_q;
  assign scan_code     = head_q.code;
  assign letter_case   = head_q.letter_case;
  assign caps_lock     = caps_lock_q;
  assign overflow_tick = overflow_q;

endmodule

// File: tb/tb_kb_scan_decoder.sv
// Bench for kb_scan_decoder: scenario tasks plus a pop-side scoreboard.
module tb_kb_scan_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rd_key = 1'b0;
  logic       key_empty;
  logic [7:0] scan_code;
  logic       letter_case;
  logic       caps_lock;
  logic       overflow_tick;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q [$];

  kb_scan_decoder #(.W_SIZE(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_done_tick  (rx_done_tick),
    .rx_data       (rx_data),
    .rd_key        (rd_key),
    .key_empty     (key_empty),
    .scan_code     (scan_code),
    .letter_case   (letter_case),
    .caps_lock     (caps_lock),
    .overflow_tick (overflow_tick)
  );

  always #5 clk = ~clk;

  // Scoreboard: every accepted pop must present the oldest expected entry
  always @(negedge clk) begin
    if (!reset && rd_key && !key_empty) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected got=%h expected none", {letter_case, scan_code});
      end else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        if ({letter_case, scan_code} !== e) begin
          bad++;
          $display("FAIL pop_entry got=%h expected=%h", {letter_case, scan_code}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // One cycle of drive, applied 1ns after the rising edge
  task automatic cyc(input logic t, input logic [7:0] d, input logic r);
    @(posedge clk);
    #1;
    rx_done_tick = t;
    rx_data      = d;
    rd_key       = r;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic pop_one();
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if ({key_empty, scan_code, letter_case, caps_lock, overflow_tick} !== 12'b1_00000000_000) begin
      bad++;
      $display("FAIL reset_outputs got=%b expected=%b",
               {key_empty, scan_code, letter_case, caps_lock, overflow_tick}, 12'b1_00000000_000);
    end
    reset = 1'b0;
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_break_code();
    send(8'h1C);
    exp_q.push_back(9'h01C);
    total++;
    if (key_empty !== 1'b0 || scan_code !== 8'h1C) begin
      bad++;
      $display("FAIL fwft_visible got empty=%b code=%h expected empty=0 code=1c", key_empty, scan_code);
    end
    send(8'hF0);
    send(8'h1C);
    pop_one();
    total++;
    if (key_empty !== 1'b1 || scan_code !== 8'h00 || letter_case !== 1'b0) begin
      bad++;
      $display("FAIL break_empty got empty=%b code=%h lc=%b expected empty=1 code=00 lc=0",
               key_empty, scan_code, letter_case);
    end
  endtask

  task automatic test_shift();
    send(8'h12);
    send(8'h1C);
    exp_q.push_back(9'h11C);
    send(8'hF0);
    send(8'h12);
    send(8'h1C);
    exp_q.push_back(9'h01C);
    pop_one();
    pop_one();
    total++;
    if (key_empty !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL shift_drain got empty=%b left=%0d expected empty=1 left=0", key_empty, exp_q.size());
    end
  endtask

  task automatic test_caps();
    send(8'h58);
    total++;
    if (caps_lock !== 1'b1) begin
      bad++;
      $display("FAIL caps_on got=%b expected=1", caps_lock);
    end
    send(8'h58);
    total++;
    if (caps_lock !== 1'b1 || key_empty !== 1'b1) begin
      bad++;
      $display("FAIL caps_repeat got caps=%b empty=%b expected caps=1 empty=1", caps_lock, key_empty);
    end
    send(8'hF0);
    send(8'h58);
    total++;
    if (caps_lock !== 1'b1) begin
      bad++;
      $display("FAIL caps_release got=%b expected=1", caps_lock);
    end
    send(8'h15);
    exp_q.push_back(9'h115);
    pop_one();
    send(8'h58);
    send(8'hF0);
    send(8'h58);
    total++;
    if (caps_lock !== 1'b0 || key_empty !== 1'b1) begin
      bad++;
      $display("FAIL caps_off got caps=%b empty=%b expected caps=0 empty=1", caps_lock, key_empty);
    end
    send(8'h15);
    exp_q.push_back(9'h015);
    pop_one();
  endtask

  task automatic test_extended();
    logic [7:0] seq [9];
    seq = '{8'hE0, 8'h12, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hAA, 8'hFA};
    for (int i = 0; i < 9; i++) begin
      send(seq[i]);
      total++;
      if (key_empty !== 1'b1) begin
        bad++;
        $display("FAIL ext_swallow idx=%0d got empty=%b expected=1", i, key_empty);
      end
    end
    // Decoded from IDLE with shift still released
    send(8'h1C);
    exp_q.push_back(9'h01C);
    pop_one();
  endtask

  task automatic test_overflow();
    logic [7:0] keys [5];
    keys = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
    for (int i = 0; i < 4; i++) begin
      send(keys[i]);
      exp_q.push_back({1'b0, keys[i]});
    end
    total++;
    if (overflow_tick !== 1'b0 || scan_code !== 8'h16) begin
      bad++;
      $display("FAIL fill_state got ovf=%b head=%h expected ovf=0 head=16", overflow_tick, scan_code);
    end
    cyc(1'b1, keys[4], 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (overflow_tick !== 1'b1) begin
      bad++;
      $display("FAIL ovf_pulse got=%b expected=1", overflow_tick);
    end
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (overflow_tick !== 1'b0) begin
      bad++;
      $display("FAIL ovf_single got=%b expected=0", overflow_tick);
    end
    // Full: simultaneous push and pop both complete
    cyc(1'b1, 8'h36, 1'b1);
    exp_q.push_back(9'h036);
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (overflow_tick !== 1'b0 || scan_code !== 8'h1E) begin
      bad++;
      $display("FAIL full_pushpop got ovf=%b head=%h expected ovf=0 head=1e", overflow_tick, scan_code);
    end
    for (int i = 0; i < 4; i++) pop_one();
    total++;
    if (key_empty !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ovf_drain got empty=%b left=%0d expected empty=1 left=0", key_empty, exp_q.size());
    end
    // Pop on empty is ignored
    pop_one();
    total++;
    if (key_empty !== 1'b1 || scan_code !== 8'h00) begin
      bad++;
      $display("FAIL empty_pop got empty=%b code=%h expected empty=1 code=00", key_empty, scan_code);
    end
  endtask

  task automatic test_back_to_back();
    // Empty: push with pop in the same cycle keeps the push
    cyc(1'b1, 8'h2C, 1'b1);
    exp_q.push_back(9'h02C);
    cyc(1'b0, 8'h00, 1'b0);
    total++;
    if (key_empty !== 1'b0 || scan_code !== 8'h2C) begin
      bad++;
      $display("FAIL empty_pushpop got empty=%b code=%h expected empty=0 code=2c", key_empty, scan_code);
    end
    // Consecutive tick cycles, including typematic repeat of a make code
    cyc(1'b1, 8'h2C, 1'b0);
    exp_q.push_back(9'h02C);
    cyc(1'b1, 8'h59, 1'b0);
    cyc(1'b1, 8'h2C, 1'b0);
    exp_q.push_back(9'h12C);
    cyc(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) pop_one();
    send(8'hF0);
    send(8'h59);
    send(8'h2C);
    exp_q.push_back(9'h02C);
    pop_one();
    total++;
    if (key_empty !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain got empty=%b left=%0d expected empty=1 left=0", key_empty, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    send(8'h58);
    send(8'h1C);
    send(8'h12);
    send(8'hF0);
    // Asynchronous assertion between clock edges
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if ({key_empty, scan_code, letter_case, caps_lock, overflow_tick} !== 12'b1_00000000_000) begin
      bad++;
      $display("FAIL async_reset got=%b expected=%b",
               {key_empty, scan_code, letter_case, caps_lock, overflow_tick}, 12'b1_00000000_000);
    end
    exp_q.delete();
    cyc(1'b0, 8'h00, 1'b0);
    reset = 1'b0;
    send(8'h1C);
    exp_q.push_back(9'h01C);
    total++;
    if (key_empty !== 1'b0 || {letter_case, scan_code} !== 9'h01C) begin
      bad++;
      $display("FAIL post_reset got empty=%b entry=%h expected empty=0 entry=01c",
               key_empty, {letter_case, scan_code});
    end
    pop_one();
  endtask

  initial begin
    test_reset();
    test_break_code();
    test_shift();
    test_caps();
    test_extended();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kb_scan_decoder.md
KB_SCAN_DECODER -- requirements
Module: kb_scan_decoder

Interface
REQ-001 Parameter: W_SIZE, default 2, key FIFO address width; FIFO depth SHALL be 2**W_SIZE entries.
REQ-002 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx_done_tick  input  1  one-cycle strobe; rx_data valid in that cycle.
REQ-005 rx_data  input  8  byte from the PS/2 receiver.
REQ-006 rd_key  input  1  pop request for the head FIFO entry.
REQ-007 key_empty  output  1  high when the FIFO holds no entries.
REQ-008 scan_code  output  8  make code of the head entry; feeds key2ascii scan_code.
REQ-009 letter_case  output  1  case flag of the head entry; feeds key2ascii letter_case.
REQ-010 caps_lock  output  1  current caps-lock state, for LED and status.
REQ-011 overflow_tick  output  1  one-cycle pulse when a key is dropped because the FIFO is full.

Function
REQ-012 Byte FSM states SHALL be IDLE, BRK (after F0), EXT (after E0) and EXT_BRK (after E0 F0); every state change SHALL be gated by rx_done_tick.
REQ-013 IDLE: F0 goes to BRK; E0 goes to EXT; 12 sets lshift; 59 sets rshift; 58 applies the caps rule; AA, FA, EE, FE, 00 and FF are discarded; any other byte is pushed; all of these except F0 and E0 stay in IDLE.
REQ-014 Caps rule: if caps_held=0, toggle caps_lock and set caps_held; if caps_held=1, do nothing (typematic repeat); 58 is never pushed.
REQ-015 BRK: 12 clears lshift; 59 clears rshift; 58 clears caps_held; any other byte is ignored; then go to IDLE; a break code is never pushed.
REQ-016 EXT: F0 goes to EXT_BRK; any other byte is discarded and goes to IDLE; extended keys, including fake shifts E0 12 and E0 59, are never pushed and never change shift state.
REQ-017 EXT_BRK: any byte is discarded and goes to IDLE.
REQ-018 A pushed entry SHALL be {letter_case, rx_data}, where letter_case = (lshift | rshift) XOR caps_lock, sampled in the push cycle before any update made in that cycle.
REQ-019 Typematic repeats of ordinary make codes SHALL be pushed each time they arrive.
REQ-020 FIFO SHALL be first-word-fall-through: a push in cycle N SHALL make the entry visible on scan_code/letter_case, with key_empty=0, in cycle N+1.
REQ-021 scan_code and letter_case SHALL be 0 while key_empty=1.
REQ-022 rd_key while empty SHALL be ignored, with no pointer change.
REQ-023 Push while full with no pop: entry dropped, pointers unchanged, overflow_tick=1 for one cycle.
REQ-024 Push and pop in the same cycle while full: both SHALL complete, count unchanged, no overflow.
REQ-025 Push and pop in the same cycle while empty: push SHALL complete, pop ignored, key_empty=0 next cycle.
REQ-026 Pointers SHALL wrap modulo 2**W_SIZE; full and empty SHALL be distinguished without losing an entry slot.
REQ-027 overflow_tick SHALL be 0 in every cycle except the one following a dropped push.

Reset
REQ-028 While reset=1, independent of clk: FSM=IDLE, lshift=rshift=caps_held=caps_lock=0, FIFO empty, key_empty=1, scan_code=0, letter_case=0, overflow_tick=0.
REQ-029 Reset asserted mid-sequence (e.g. after F0) SHALL discard the prefix; the first byte after release SHALL be decoded from IDLE.

Verification
REQ-030 Bytes 1C, F0, 1C then one rd_key -> exactly one entry {0,1C}; key_empty=1 after the pop.
REQ-031 Bytes 12, 1C, F0, 12, 1C -> entries {1,1C} then {0,1C}; lshift=0 at the end.
REQ-032 Bytes 58, 58, F0, 58, 15 -> caps_lock=1 throughout after the first 58; one entry {1,15}; bytes 58, F0, 58 again -> caps_lock=0.
REQ-033 Bytes E0, 12, E0, 75, E0, F0, 75, AA, FA -> FIFO stays empty, shift state unchanged, FSM=IDLE.
REQ-034 With W_SIZE=2: five make codes 16, 1E, 26, 25, 2E and no reads -> fifth dropped, one overflow_tick pulse; reads return 16, 1E, 26, 25; a push with rd_key in the same cycle while full -> no overflow.
REQ-035 Reset pulse after bytes 12, F0 -> shift cleared; next byte 1C -> entry {0,1C}.
